// File: rtl/axi_sram_slave_if.sv
// AXI4 channel bundle between an AXI master and the single-port SRAM slave.
// One outstanding transaction; ID width is the only parameter.
interface axi_sram_slave_if #(
  parameter int ID_BITS = 8
);
  logic [ID_BITS-1:0] AWID;
  logic [31:0]        AWADDR;
  logic [3:0]         AWLEN;
  logic [2:0]         AWSIZE;
  logic [1:0]         AWBURST;
  logic               AWVALID;
  logic               AWREADY;

  logic [31:0]        WDATA;
  logic [3:0]         WSTRB;
  logic               WLAST;
  logic               WVALID;
  logic               WREADY;

  logic [ID_BITS-1:0] BID;
  logic [1:0]         BRESP;
  logic               BVALID;
  logic               BREADY;

  logic [ID_BITS-1:0] ARID;
  logic [31:0]        ARADDR;
  logic [3:0]         ARLEN;
  logic [2:0]         ARSIZE;
  logic [1:0]         ARBURST;
  logic               ARVALID;
  logic               ARREADY;

  logic [ID_BITS-1:0] RID;
  logic [31:0]        RDATA;
  logic [1:0]         RRESP;
  logic               RLAST;
  logic               RVALID;
  logic               RREADY;

  modport slave (
    input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    output AWREADY,
    input  WDATA, WSTRB, WLAST, WVALID,
    output WREADY,
    output BID, BRESP, BVALID,
    input  BREADY,
    input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    output ARREADY,
    output RID, RDATA, RRESP, RLAST, RVALID,
    input  RREADY
  );

  modport master (
    output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    input  AWREADY,
    output WDATA, WSTRB, WLAST, WVALID,
    input  WREADY,
    input  BID, BRESP, BVALID,
    output BREADY,
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    input  ARREADY,
    input  RID, RDATA, RRESP, RLAST, RVALID,
    output RREADY
  );
endinterface

// File: rtl/axi_sram_slave.sv
// AXI4 slave bridging one outstanding burst at a time onto a 32-bit single-port SRAM
// with one-cycle read latency. Reads win over writes when both arrive together.
module axi_sram_slave #(
  parameter int ID_BITS = 8,
  parameter int MEM_AW  = 14
) (
  input  logic               ACLK,
  input  logic               ARESETn,
  axi_sram_slave_if.slave    axi,
  output logic               mem_en,
  output logic [3:0]         mem_we,
  output logic [MEM_AW-1:0]  mem_addr,
  output logic [31:0]        mem_wdata,
  input  logic [31:0]        mem_rdata
);

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    R_FETCH,
    R_CAPT,
    R_DATA,
    W_DATA,
    W_RESP
  } state_t;

  state_t             state, state_nxt;

  logic [ID_BITS-1:0] id_q;
  logic [MEM_AW-1:0]  addr_q;
  logic [3:0]         len_q;
  logic [3:0]         beat_q;
  logic [1:0]         burst_q;
  logic               err_q;
  logic [31:0]        rdata_q;

  logic               last;
  logic               ar_hs, aw_hs, w_hs, r_hs;
  logic               arready, awready, wready, rvalid, bvalid;
  logic               mem_en_c;
  logic [3:0]         mem_we_c;
  logic [31:0]        mem_wdata_c;

  // FIXED holds the word address; INCR and the unsupported WRAP/reserved types step by one
  // and wrap at the top of the SRAM.
  function automatic logic [MEM_AW-1:0] next_addr(input logic [MEM_AW-1:0] a,
                                                   input logic [1:0]        burst);
    return (burst == BURST_FIXED) ? a : a + MEM_AW'(1);
  endfunction

  assign last = (beat_q == len_q);

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    ar_hs       = 1'b0;
    aw_hs       = 1'b0;
    w_hs        = 1'b0;
    r_hs        = 1'b0;
    arready     = 1'b0;
    awready     = 1'b0;
    wready      = 1'b0;
    rvalid      = 1'b0;
    bvalid      = 1'b0;
    mem_en_c    = 1'b0;
    mem_we_c    = 4'h0;
    mem_wdata_c = 32'h0;
    case (state)
      IDLE: begin
        // Ready outputs are qualified by ARESETn so nothing is offered while held in reset.
        arready = ARESETn;
        awready = ARESETn && !axi.ARVALID;
        if (axi.ARVALID) begin
          ar_hs     = 1'b1;
          state_nxt = R_FETCH;
        end else if (axi.AWVALID) begin
          aw_hs     = 1'b1;
          state_nxt = W_DATA;
        end
      end
      R_FETCH: begin
        mem_en_c  = 1'b1;
        state_nxt = R_CAPT;
      end
      R_CAPT: state_nxt = R_DATA;
      R_DATA: begin
        rvalid = 1'b1;
        if (axi.RREADY) begin
          r_hs      = 1'b1;
          state_nxt = last ? IDLE : R_FETCH;
        end
      end
      W_DATA: begin
        wready = 1'b1;
        if (axi.WVALID) begin
          w_hs        = 1'b1;
          mem_en_c    = 1'b1;
          mem_we_c    = axi.WSTRB;
          mem_wdata_c = axi.WDATA;
          if (last) state_nxt = W_RESP;
        end
      end
      W_RESP: begin
        bvalid = 1'b1;
        if (axi.BREADY) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      id_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      burst_q <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      if (ar_hs) begin
        id_q    <= axi.ARID;
        addr_q  <= axi.ARADDR[MEM_AW+1:2];
        len_q   <= axi.ARLEN;
        burst_q <= axi.ARBURST;
        beat_q  <= '0;
        err_q   <= axi.ARBURST[1];
      end else if (aw_hs) begin
        id_q    <= axi.AWID;
        addr_q  <= axi.AWADDR[MEM_AW+1:2];
        len_q   <= axi.AWLEN;
        burst_q <= axi.AWBURST;
        beat_q  <= '0;
        err_q   <= axi.AWBURST[1];
      end
      if (state == R_CAPT) rdata_q <= mem_rdata;
      if (r_hs && !last) begin
        beat_q <= beat_q + 4'd1;
        addr_q <= next_addr(addr_q, burst_q);
      end
      // The beat count, not WLAST, ends a write burst; a disagreeing WLAST only flags the error.
      if (w_hs) begin
        if (axi.WLAST != last) err_q <= 1'b1;
        if (!last) begin
          beat_q <= beat_q + 4'd1;
          addr_q <= next_addr(addr_q, burst_q);
        end
      end
    end
  end

  assign axi.ARREADY = arready;
  assign axi.AWREADY = awready;
  assign axi.WREADY  = wready;
  assign axi.RVALID  = rvalid;
  assign axi.RDATA   = rdata_q;
  assign axi.RID     = id_q;
  assign axi.RLAST   = rvalid && last;
  assign axi.RRESP   = (rvalid && err_q) ? RESP_SLVERR : RESP_OKAY;
  assign axi.BVALID  = bvalid;
  assign axi.BID     = id_q;
  assign axi.BRESP   = (bvalid && err_q) ? RESP_SLVERR : RESP_OKAY;

  assign mem_en    = mem_en_c;
  assign mem_we    = mem_we_c;
  assign mem_addr  = addr_q;
  assign mem_wdata = mem_wdata_c;

  logic unused_bits;
  assign unused_bits = ^{axi.AWSIZE, axi.ARSIZE,
                         axi.AWADDR[31:MEM_AW+2], axi.AWADDR[1:0],
                         axi.ARADDR[31:MEM_AW+2], axi.ARADDR[1:0]};

endmodule
